// File: rtl/iris_score_collector.sv
// iris_score_collector
// Scores each training sample of the IRIS ODESA loop. A sample starts on the
// rising edge of |i_test_vector; the block then waits up to WINDOW cycles for
// an output-layer spike and classifies the sample as correct, wrong,
// no-response or bad label. Running per-epoch counters are snapshotted to the
// o_* score outputs on each rising edge of i_end_of_epochs.
//
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_test_vector      20-bit feature spike vector (all zero = idle)
//   i_label            3-bit one-hot class label, latched at sample onset
//   i_end_of_epochs    end-of-training level; its rising edge closes an epoch
//   i_out_spike        output-layer spikes, one bit per class
//   o_sample_done      one-cycle verdict pulse
//   o_verdict          00 no-response, 01 correct, 10 wrong, 11 bad label
//   o_total/o_correct/o_noresp/o_badlabel  epoch snapshot counters
//   o_epoch_done       one-cycle pulse, snapshot updated in the same cycle
//
// state | meaning
// IDLE  | no sample pending; output spikes are ignored
// WAIT  | sample pending; window counter running
module iris_score_collector #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [19:0]      i_test_vector,
  input  logic [2:0]       i_label,
  input  logic             i_end_of_epochs,
  input  logic [2:0]       i_out_spike,
  output logic             o_sample_done,
  output logic [1:0]       o_verdict,
  output logic [CNT_W-1:0] o_total,
  output logic [CNT_W-1:0] o_correct,
  output logic [CNT_W-1:0] o_noresp,
  output logic [CNT_W-1:0] o_badlabel,
  output logic             o_epoch_done
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [9:0] WIN_LAST = 10'(WINDOW - 1);
  localparam logic [1:0] V_NORESP = 2'b00;
  localparam logic [1:0] V_CORR   = 2'b01;
  localparam logic [1:0] V_WRONG  = 2'b10;
  localparam logic [1:0] V_BAD    = 2'b11;

  state_t     state_q, state_d;
  logic [9:0] win_q, win_d;
  logic [2:0] lab_q, lab_d;
  logic       bad_q, bad_d;
  logic       vec_or_q, eoe_q;
  logic       onset, close;
  logic       vld;
  logic [1:0] code;

  logic [CNT_W-1:0] tot_r, cor_r, nr_r, bad_r;
  logic [CNT_W-1:0] tot_n, cor_n, nr_n, bad_n;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  assign onset = (|i_test_vector) && !vec_or_q;
  assign close = i_end_of_epochs && !eoe_q;

  // A new onset pre-empts a pending sample (closed without a response, even
  // if a spike arrives in the same cycle). A same-cycle spike beats both the
  // window timeout and an epoch close, so its verdict is what gets counted.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lab_d   = lab_q;
    bad_d   = bad_q;
    vld     = 1'b0;
    code    = V_NORESP;
    if (state_q == WAIT) begin
      if (onset) begin
        vld  = 1'b1;
        code = bad_q ? V_BAD : V_NORESP;
      end else if (|i_out_spike) begin
        vld     = 1'b1;
        state_d = IDLE;
        if (bad_q)
          code = V_BAD;
        else if (is_onehot(i_out_spike) && (i_out_spike == lab_q))
          code = V_CORR;
        else
          code = V_WRONG;
      end else if ((win_q == WIN_LAST) || close) begin
        vld     = 1'b1;
        state_d = IDLE;
        code    = bad_q ? V_BAD : V_NORESP;
      end else begin
        win_d = win_q + 10'd1;
      end
    end
    if (onset) begin
      state_d = WAIT;
      win_d   = 10'd0;
      lab_d   = i_label;
      bad_d   = !is_onehot(i_label);
    end else if (close) begin
      state_d = IDLE;
    end
  end

  assign tot_n = sat_inc(tot_r, vld);
  assign cor_n = sat_inc(cor_r, vld && (code == V_CORR));
  assign nr_n  = sat_inc(nr_r,  vld && (code == V_NORESP));
  assign bad_n = sat_inc(bad_r, vld && (code == V_BAD));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      win_q         <= '0;
      lab_q         <= '0;
      bad_q         <= 1'b0;
      vec_or_q      <= 1'b0;
      eoe_q         <= 1'b0;
      tot_r         <= '0;
      cor_r         <= '0;
      nr_r          <= '0;
      bad_r         <= '0;
      o_sample_done <= 1'b0;
      o_verdict     <= '0;
      o_total       <= '0;
      o_correct     <= '0;
      o_noresp      <= '0;
      o_badlabel    <= '0;
      o_epoch_done  <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      lab_q         <= lab_d;
      bad_q         <= bad_d;
      vec_or_q      <= |i_test_vector;
      eoe_q         <= i_end_of_epochs;
      o_sample_done <= vld;
      o_verdict     <= code;
      o_epoch_done  <= close;
      if (close) begin
        // Snapshot includes any verdict made in the closing cycle.
        o_total    <= tot_n;
        o_correct  <= cor_n;
        o_noresp   <= nr_n;
        o_badlabel <= bad_n;
        tot_r      <= '0;
        cor_r      <= '0;
        nr_r       <= '0;
        bad_r      <= '0;
      end else begin
        tot_r <= tot_n;
        cor_r <= cor_n;
        nr_r  <= nr_n;
        bad_r <= bad_n;
      end
    end
  end

endmodule

// File: doc/iris_score_collector.md
# iris_score_collector

Sink-side scoring block for the IRIS ODESA training loop. It sits downstream of `iris_auto_trainer` and alongside the network's output layer. It observes each 20-bit feature spike vector and its 3-bit one-hot label, and waits a bounded window for an output-layer spike. It then classifies each sample as correct, wrong, or no-response, and publishes per-epoch score counters when the trainer signals end of epochs.

## Interface
Parameters:
- `WINDOW`, 64: response window in cycles, counted from sample onset; legal range 2..1023.
- `CNT_W`, 16: width of all score counters.

Ports:
- `i_clk`, in, 1: single clock; all logic is rising-edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_test_vector`, in, 20: feature spike vector from the trainer; all zero means idle.
- `i_label`, in, 3: one-hot class label from the trainer.
- `i_end_of_epochs`, in, 1: end-of-training level from the trainer.
- `i_out_spike`, in, 3: output-layer spikes, one bit per class.
- `o_sample_done`, out, 1: one-cycle pulse when a sample verdict is made.
- `o_verdict`, out, 2: verdict code, valid with `o_sample_done`. Codes: 00 = no-response, 01 = correct, 10 = wrong, 11 = bad label.
- `o_total`, out, CNT_W: snapshot of the number of samples in the epoch.
- `o_correct`, out, CNT_W: snapshot of the correct count.
- `o_noresp`, out, CNT_W: snapshot of the no-response count.
- `o_badlabel`, out, CNT_W: snapshot of the bad-label count.
- `o_epoch_done`, out, 1: one-cycle pulse; the snapshot is updated in the same cycle.

## Operation
- Onset: `|i_test_vector` is 1 in this cycle and was 0 in the previous cycle. A registered copy of the OR is required for this.
- At onset:
  - Latch `i_label` into `lab_q`.
  - Load the window counter `win_q` with 0.
  - If `i_label` is not one-hot (popcount ≠ 1), flag the sample as bad label.
- State machine:
  - IDLE: on onset, go to WAIT.
  - WAIT: increment `win_q` every cycle.
    - On the first cycle with `i_out_spike` ≠ 0, decide the verdict and go to IDLE.
      - If `i_out_spike` is one-hot, compare it with `lab_q`: equal gives correct, otherwise wrong.
      - If multiple bits are set, the verdict is wrong.
    - If `win_q` reaches WINDOW−1 with no spike, the verdict is no-response; go to IDLE.
- Output spikes seen in IDLE are ignored.
- Bad-label samples still run the window. Their verdict is forced to 11 and they do not increment correct or noresp.
- Running counters `tot_r`, `cor_r`, `nr_r`, `bad_r`:
  - Increment on each verdict.
  - Saturate at 2^CNT_W−1; never wrap.
- Epoch close happens on the rising edge of `i_end_of_epochs`:
  - Copy the running counters to the `o_*` snapshot registers.
  - Pulse `o_epoch_done`.
  - Clear the running counters.
  - Return to IDLE.
- The `o_*` snapshot registers hold their value until the next epoch close.

## Timing
- All outputs are registered. Reset values: every output is 0, state is IDLE, all counters are 0, and the onset history is 0.
- Verdict latency:
  - A spike first seen in cycle N (in WAIT) gives `o_sample_done` = 1 in cycle N+1.
  - No-response is reported WINDOW+1 cycles after the onset cycle.
- The earliest legal spike is in the cycle after onset. A spike in the onset cycle itself is ignored.
- New onset while in WAIT:
  - The pending sample is closed as no-response, or as bad label if it was flagged.
  - The new sample starts in the same cycle; its window restarts at 0.
  - Exactly one `o_sample_done` pulse is emitted.
- Epoch-close edge while in WAIT:
  - The pending sample is closed as no-response (or bad label).
  - Its count is included in the snapshot.
  - `o_sample_done` and `o_epoch_done` pulse in the same cycle.
- Epoch-close edge coinciding with a verdict-producing spike: the verdict from the spike is counted and included in the snapshot.
- Epoch-close edge coinciding with an onset: the snapshot is taken first, then the new sample starts, counting into the fresh epoch.
- `i_end_of_epochs` held high produces one close only. Rising-edge detection requires a registered copy.
- Reset asserted mid-window:
  - All state clears immediately (asynchronous).
  - No verdict or epoch pulse is produced for the interrupted sample.

## Test plan
- Correct classification: label 3'b010, onset, `i_out_spike` = 3'b010 five cycles later. Expected: one `o_sample_done` with `o_verdict` = 01. Then raise `i_end_of_epochs`; expected `o_total` = 1, `o_correct` = 1, `o_noresp` = 0, `o_badlabel` = 0.
- Wrong and multi-hot: label 3'b001 with spike 3'b100 gives 10. A second sample with spike 3'b011 gives 10. Epoch close gives `o_total` = 2, `o_correct` = 0.
- No-response with WINDOW = 8: onset at cycle 0 and no spikes. Expected `o_sample_done` with 00 exactly at cycle 9. An output spike at cycle 12 produces no pulse.
- Overlap and bad label:
  - Sample A (label 3'b100) onsets; the vector goes to 0; sample B onsets after 3 cycles. Expected: A is closed as 00 in the same cycle B starts.
  - Sample C with label 3'b110 is then answered with a spike. Expected verdict 11 and `o_badlabel` = 1 after close.
- Epoch edge mid-window: onset, then `i_end_of_epochs` rises 2 cycles later. Expected: `o_sample_done` (00) and `o_epoch_done` in the same cycle, with `o_noresp` = 1. A second epoch with no samples gives all-zero snapshots.
- Saturation and reset: with CNT_W = 4, run 20 correct samples; expected `o_correct` = 15 and `o_total` = 15. Assert `i_rst_n` = 0 mid-window; expected all outputs 0 asynchronously and no pulses after release.
